// File: rtl/serial_fadd.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Start/done handshake; sum and cout hold from DONE until the next accepted start.
module serial_fadd #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          carry;
    logic [CW-1:0] cnt;

    logic s_bit;
    logic c_next;
    logic accept;

    // Single full-adder cell on the current LSBs
    assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    // A new operation may start from IDLE or directly from DONE
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
                sum   <= '0;
                cout  <= 1'b0;
                busy  <= 1'b1;
                state <= RUN;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        carry <= c_next;
                        sum   <= (sum >> 1) | (W'(s_bit) << (W - 1));
                        a_sr  <= a_sr >> 1;
                        b_sr  <= b_sr >> 1;
                        cnt   <= cnt + CW'(1);
                        // Last bit: latch the final carry and hand off to DONE
                        if (cnt == CW'(W - 1)) begin
                            cout  <= c_next;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_fadd.sv
// Bench for serial_fadd: W=8 directed scenarios, W=3 and W=1 exhaustive,
// expected results queued at acceptance and compared when done is seen.
module tb_serial_fadd;

    logic clk;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    logic [8:0] q8[$];
    logic [3:0] q3[$];
    logic [1:0] q1[$];

    int vectors = 0;
    int miscompares = 0;

    serial_fadd #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_fadd #(.W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );
    serial_fadd #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One W=8 operation with start pulsed for a single cycle
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input string nm);
        int edges;
        int busy_cnt;
        logic [8:0] exp;
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        q8.push_back(9'(av) + 9'(bv) + 9'(cv));
        tick();
        start8 = 1'b0;
        edges = 1;
        busy_cnt = 0;
        while (done8 !== 1'b1 && edges < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            tick();
            edges++;
        end
        vectors++;
        if (edges !== 9) begin
            miscompares++;
            $display("FAIL %s latency: got %0d edges, expected 9", nm, edges);
        end
        vectors++;
        if (busy_cnt !== 8) begin
            miscompares++;
            $display("FAIL %s busy: got %0d cycles, expected 8", nm, busy_cnt);
        end
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h0;
        vectors++;
        if ({cout8, sum8} !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h, expected %h", nm, {cout8, sum8}, exp);
        end
        tick();
        vectors++;
        if (done8 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_width: done still %b, expected 0", nm, done8);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start3 = 0; a3 = 0; b3 = 0; cin3 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        tick();
        tick();
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset: got %h, expected 0", {busy8, done8, cout8, sum8});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        op8(8'h5A, 8'h33, 1'b0, "basic");
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if ({busy8, done8, cout8, sum8} !== {3'b000, 8'h8D}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got %h, expected %h", i, {busy8, done8, cout8, sum8}, {3'b000, 8'h8D});
            end
        end
    endtask

    task automatic test_carry();
        op8(8'hFF, 8'h01, 1'b0, "carry_ff_01");
        op8(8'hFF, 8'hFF, 1'b1, "carry_ff_ff_1");
        op8(8'h00, 8'h00, 1'b1, "carry_00_00_1");
    endtask

    task automatic test_ignore_start();
        int pulses;
        logic [8:0] exp;
        logic [8:0] got;
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h08D);
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        pulses = 0;
        got = 9'h0;
        for (int i = 0; i < 20; i++) begin
            if (done8 === 1'b1) begin
                pulses++;
                got = {cout8, sum8};
            end
            tick();
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL ignore_start pulses: got %0d, expected 1", pulses);
        end
        exp = (q8.size() > 0) ? q8.pop_front() : 9'h0;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ignore_start result: got %h, expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h08D);
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        q8.delete();
        #1;
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got %h, expected 0", {busy8, done8, cout8, sum8});
        end
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) pulses++;
            tick();
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL reset_mid pulses: got %0d, expected 0", pulses);
        end
        op8(8'h10, 8'h20, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] av[4] = '{8'h5A, 8'hFF, 8'h80, 8'h0F};
        logic [7:0] bv[4] = '{8'h33, 8'h01, 8'h80, 8'hF1};
        logic       cv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int edges;
        logic [8:0] exp;
        a8 = av[0]; b8 = bv[0]; cin8 = cv[0]; start8 = 1'b1;
        q8.push_back(9'(av[0]) + 9'(bv[0]) + 9'(cv[0]));
        tick();
        for (int i = 0; i < 4; i++) begin
            edges = 1;
            while (done8 !== 1'b1 && edges < 40) begin
                tick();
                edges++;
            end
            vectors++;
            if (edges !== 9) begin
                miscompares++;
                $display("FAIL b2b[%0d] period: got %0d edges, expected 9", i, edges);
            end
            exp = (q8.size() > 0) ? q8.pop_front() : 9'h0;
            vectors++;
            if ({cout8, sum8} !== exp) begin
                miscompares++;
                $display("FAIL b2b[%0d] result: got %h, expected %h", i, {cout8, sum8}, exp);
            end
            if (i < 3) begin
                a8 = av[i+1]; b8 = bv[i+1]; cin8 = cv[i+1];
                q8.push_back(9'(av[i+1]) + 9'(bv[i+1]) + 9'(cv[i+1]));
            end else begin
                start8 = 1'b0;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_w3_exhaustive();
        int edges;
        logic [3:0] exp;
        for (int i = 0; i < 128; i++) begin
            a3 = 3'(i >> 4); b3 = 3'(i >> 1); cin3 = 1'(i);
            q3.push_back(4'(a3) + 4'(b3) + 4'(cin3));
            start3 = 1'b1;
            tick();
            start3 = 1'b0;
            edges = 1;
            while (done3 !== 1'b1 && edges < 20) begin
                tick();
                edges++;
            end
            exp = (q3.size() > 0) ? q3.pop_front() : 4'h0;
            vectors++;
            if (edges !== 4 || {cout3, sum3} !== exp) begin
                miscompares++;
                $display("FAIL w3[%0d]: got %h after %0d edges, expected %h after 4", i, {cout3, sum3}, edges, exp);
            end
        end
    endtask

    task automatic test_w1_exhaustive();
        int edges;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            q1.push_back(2'(a1) + 2'(b1) + 2'(cin1));
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            edges = 1;
            while (done1 !== 1'b1 && edges < 20) begin
                tick();
                edges++;
            end
            exp = (q1.size() > 0) ? q1.pop_front() : 2'h0;
            vectors++;
            if (edges !== 2 || {cout1, sum1} !== exp) begin
                miscompares++;
                $display("FAIL w1[%0d]: got %h after %0d edges, expected %h after 2", i, {cout1, sum1}, edges, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_w3_exhaustive();
        test_w1_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
